palette_lut: RTL and testbench
==============================

Name: palette_lut

Overview:
- Runtime-programmable colour look-up table for the sprite decoder. Replaces the fixed per-sprite palette ROMs.
- Holds NUM_PALETTES banks of 2^INDEX_W entries, each a 24-bit RGB colour.
- Converts a stream of pixel indices into RGB with a fixed 2-cycle latency and flags transparent pixels.
- Sits between the sprite pixel fetcher and the layer compositor. The CPU/loader side programs colours through a single write port.

Parameters:
- NUM_PALETTES, 4, number of palette banks (one per player/sprite class); must be ≥1.
- INDEX_W, 4, width of pixel index; 2^INDEX_W entries per bank; must be 1..8.
- TRANSPARENT_IDX, 0, index value reported as transparent in every bank.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  synchronous active-low reset.
- i_valid  input  1  read request this cycle.
- i_pal_sel  input  max(1,$clog2(NUM_PALETTES))  bank for the read.
- i_index  input  INDEX_W  pixel index for the read.
- i_wr_en  input  1  write strobe.
- i_wr_pal  input  max(1,$clog2(NUM_PALETTES))  bank for the write.
- i_wr_idx  input  INDEX_W  entry for the write.
- i_wr_data  input  24  RGB colour, {R[23:16], G[15:8], B[7:0]}.
- o_valid  output  1  o_color/o_transparent valid.
- o_color  output  24  looked-up colour.
- o_transparent  output  1  index equalled TRANSPARENT_IDX.
- o_init_busy  output  1  default-content sweep in progress.

Behaviour:
- Reset values: when i_rst_n=0 at a clock edge, the following take effect:
  - o_valid=0, o_color=0, o_transparent=0.
  - Pipeline valids cleared.
  - o_init_busy=1.
  - Sweep counter=0.
- FSM states: INIT and RUN.
  - Reset enters INIT.
  - INIT writes one entry per cycle with the default content.
  - Default entry k of every bank = {3{k[INDEX_W-1:0] << (8-INDEX_W)}} (grey ramp; for INDEX_W=4, k=15 → 24'hF0F0F0).
  - Banks are swept in order 0..NUM_PALETTES-1, entries 0..2^INDEX_W-1.
  - The sweep takes NUM_PALETTES*2^INDEX_W cycles (64 at defaults).
  - The cycle after the last write, the FSM enters RUN and o_init_busy=0.
  - Reset asserted mid-sweep restarts the sweep from bank 0, entry 0.
- During INIT:
  - i_valid and i_wr_en are ignored (dropped, not queued).
  - o_valid stays 0.
- Read pipeline (RUN):
  - Request sampled at edge N.
  - Memory read registered at N+1.
  - o_valid, o_color and o_transparent are registered at N+2.
  - Latency is exactly 2 cycles. Throughput is 1 per cycle, with no backpressure.
  - o_valid tracks i_valid delayed by 2.
  - When o_valid=0, o_color and o_transparent hold their previous values.
  - o_transparent = (index == TRANSPARENT_IDX). For transparent pixels o_color still reports the stored colour.
- Write port:
  - A write is accepted in any RUN cycle with i_wr_en=1.
  - The memory updates at that edge.
- Same-cycle collision:
  - A read and a write to the same (bank, entry) sampled at the same edge: the read returns i_wr_data (write-first bypass).
  - A write at N+1 to an address read at N does not affect that read's result.
- Out-of-range indices:
  - i_pal_sel ≥ NUM_PALETTES on a read returns o_color=0, with o_transparent computed normally.
  - A write with i_wr_pal ≥ NUM_PALETTES is discarded.
- The memory is an inferable single-write/single-read array; there is no reset of array contents other than the INIT sweep.

Optional Feature:
- Macro: PALETTE_FLASH_EN.
- When defined:
  - Adds input i_flash (1 bit), sampled with the read request and pipelined alongside it.
  - If set and the pixel is not transparent, o_color=24'hFFFFFF (hit-flash effect).
  - Transparent pixels are unaffected.
  - Memory is not modified.
- When undefined:
  - No i_flash port.
  - o_color is always the stored or bypassed value.

Test Plan:
- Reset, then idle: o_init_busy=1 for exactly 64 cycles, then 0. Reading bank 2, index 15 gives o_color=24'hF0F0F0 and o_transparent=0 two cycles later. Index 0 gives 24'h000000 with o_transparent=1.
- Write bank 1 idx 3 = 24'hACF52A, then stream reads of idx 0..15 on bank 1 back-to-back:
  - o_valid=1 for 16 consecutive cycles, starting 2 cycles after the first request.
  - Entry 3 = 24'hACF52A.
  - Other entries follow the grey ramp.
  - Bank 0 idx 3 is unchanged (24'h303030).
- Same-edge write bank 0 idx 5 = 24'hDF52FF with a read of bank 0 idx 5: output 24'hDF52FF. A write at N+1 with a read at N: output is the old value 24'h505050.
- Assert i_rst_n=0 for 1 cycle at sweep cycle 30 (and separately mid-RUN, after writes):
  - Sweep restarts and lasts a full 64 cycles.
  - Reads and writes issued during the sweep produce no o_valid.
  - Previously written entries revert to the default ramp.
- Reads with i_pal_sel=3 under NUM_PALETTES=3 return 24'h000000. A write to bank 3 is discarded. Bank 0 is not aliased.
- With PALETTE_FLASH_EN defined: i_flash=1 on idx 7 → 24'hFFFFFF; i_flash=1 on idx 0 → stored colour with o_transparent=1. The next read of idx 7 with i_flash=0 returns the stored colour.

Source files
------------

// File: rtl/palette_lut.sv
// palette_lut: runtime-programmable RGB palette banks with a 2-cycle index-to-colour pipeline
// Ports: i_clk/i_rst_n (sync, active-low) | read: i_valid, i_pal_sel, i_index
//        write: i_wr_en, i_wr_pal, i_wr_idx, i_wr_data {R,G,B}
//        out: o_valid, o_color, o_transparent, o_init_busy (grey-ramp sweep after reset)
// Option: define PALETTE_FLASH_EN to add i_flash (non-transparent pixels forced to white)
module palette_lut #(
  parameter int NUM_PALETTES = 4,
  parameter int INDEX_W = 4,
  parameter int TRANSPARENT_IDX = 0,
  localparam int PW = NUM_PALETTES > 1 ? $clog2(NUM_PALETTES) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic [PW-1:0]      i_pal_sel,
  input  logic [INDEX_W-1:0] i_index,
  input  logic               i_wr_en,
  input  logic [PW-1:0]      i_wr_pal,
  input  logic [INDEX_W-1:0] i_wr_idx,
  input  logic [23:0]        i_wr_data,
`ifdef PALETTE_FLASH_EN
  input  logic               i_flash,
`endif
  output logic               o_valid,
  output logic [23:0]        o_color,
  output logic               o_transparent,
  output logic               o_init_busy
);
  localparam int AW = PW + INDEX_W;
  localparam logic [AW-1:0] LAST = AW'(NUM_PALETTES * (2 ** INDEX_W) - 1);
  localparam logic [PW:0] NP = (PW + 1)'(NUM_PALETTES);
  localparam logic [INDEX_W-1:0] T_IDX = INDEX_W'(TRANSPARENT_IDX);
  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t r_state;
  logic [AW-1:0] r_cnt, r_addr, w_waddr;
  logic [23:0] r_mem [2 ** AW];
  logic [23:0] r_rd, w_wdata, w_color;
  logic [7:0] w_grey;
  logic w_run, w_we, r_v1, r_v2, r_tr1, r_tr2, r_oob1, r_oob2;
  assign w_run = r_state == S_RUN;
  assign w_grey = 8'(r_cnt[INDEX_W-1:0]) << (8 - INDEX_W);
  // the sweep counter is linear bank*2^INDEX_W+entry, i.e. the same layout as {bank, entry}
  assign w_we = w_run ? i_wr_en && {1'b0, i_wr_pal} < NP : 1'b1;
  assign w_waddr = w_run ? {i_wr_pal, i_wr_idx} : r_cnt;
  assign w_wdata = w_run ? i_wr_data : {3{w_grey}};
`ifdef PALETTE_FLASH_EN
  logic r_fl1, r_fl2;
  assign w_color = r_fl2 && !r_tr2 ? 24'hFFFFFF : r_oob2 ? 24'h0 : r_rd;
`else
  assign w_color = r_oob2 ? 24'h0 : r_rd;
`endif
  // reading from the registered address one edge after the request makes a write sampled
  // at the request edge visible (write-first) while a write one edge later is not
  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    r_rd <= r_mem[r_addr];
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_INIT;
      r_cnt <= '0;
      o_init_busy <= 1'b1;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      o_valid <= 1'b0;
      o_color <= '0;
      o_transparent <= 1'b0;
    end else begin
      if (!w_run) begin
        r_cnt <= r_cnt + AW'(1);
        if (r_cnt == LAST) begin
          r_state <= S_RUN;
          o_init_busy <= 1'b0;
        end
      end
      r_v1 <= w_run && i_valid;
      r_v2 <= r_v1;
      o_valid <= r_v2;
      r_addr <= {i_pal_sel, i_index};
      r_tr1 <= i_index == T_IDX;
      r_oob1 <= {1'b0, i_pal_sel} >= NP;
      r_tr2 <= r_tr1;
      r_oob2 <= r_oob1;
`ifdef PALETTE_FLASH_EN
      r_fl1 <= i_flash;
      r_fl2 <= r_fl1;
`endif
      if (r_v2) begin
        o_color <= w_color;
        o_transparent <= r_tr2;
      end
    end
  end
endmodule

// File: tb/tb_palette_lut.sv
// tb_palette_lut: randomized + directed check of palette_lut (4 banks and 3 banks) against a behavioural model
module tb_palette_lut;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0, valid = 1'b0, wr_en = 1'b0, flash = 1'b0;
  logic [1:0] pal = '0, wr_pal = '0;
  logic [3:0] idx = '0, wr_idx = '0;
  logic [23:0] wr_data = '0;
  logic ov[2], ot[2], ob[2];
  logic [23:0] oc[2];
  palette_lut #(.NUM_PALETTES(4)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_pal_sel(pal), .i_index(idx),
    .i_wr_en(wr_en), .i_wr_pal(wr_pal), .i_wr_idx(wr_idx), .i_wr_data(wr_data),
`ifdef PALETTE_FLASH_EN
    .i_flash(flash),
`endif
    .o_valid(ov[0]), .o_color(oc[0]), .o_transparent(ot[0]), .o_init_busy(ob[0]));
  palette_lut #(.NUM_PALETTES(3)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_pal_sel(pal), .i_index(idx),
    .i_wr_en(wr_en), .i_wr_pal(wr_pal), .i_wr_idx(wr_idx), .i_wr_data(wr_data),
`ifdef PALETTE_FLASH_EN
    .i_flash(flash),
`endif
    .o_valid(ov[1]), .o_color(oc[1]), .o_transparent(ot[1]), .o_init_busy(ob[1]));
  typedef struct {bit v; logic [23:0] c; bit t;} ent_t;
  int np[2] = '{4, 3};
  logic [23:0] mem[2][4][16];
  int init_left[2];
  ent_t p1[2], p2[2];
  bit mv[2], mt[2];
  logic [23:0] mc[2];
  int n_cmp = 0, n_bad = 0;
  function automatic logic [23:0] ramp(int k);
    return 24'(k * 16 * 65793);
  endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      ent_t n;
      n = '{v: 1'b0, c: 24'h0, t: 1'b0};
      if (!rst_n) begin
        init_left[d] = np[d] * 16;
        for (int b = 0; b < 4; b++) for (int k = 0; k < 16; k++) mem[d][b][k] = ramp(k);
        p1[d] = n; p2[d] = n; mv[d] = 0; mc[d] = 0; mt[d] = 0;
      end else begin
        if (p2[d].v) begin mc[d] = p2[d].c; mt[d] = p2[d].t; end
        mv[d] = p2[d].v;
        p2[d] = p1[d];
        if (init_left[d] > 0) init_left[d]--;
        else begin
          if (wr_en && int'(wr_pal) < np[d]) mem[d][wr_pal][wr_idx] = wr_data;
          if (valid) begin
            n.v = 1'b1;
            n.t = idx == 0;
            n.c = int'(pal) < np[d] ? mem[d][pal][idx] : 24'h0;
`ifdef PALETTE_FLASH_EN
            if (flash && !n.t) n.c = 24'hFFFFFF;
`endif
          end
        end
        p1[d] = n;
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("busy%0d", d), ob[d], init_left[d] != 0);
      check($sformatf("valid%0d", d), ov[d], mv[d]);
      check($sformatf("color%0d", d), oc[d], mc[d]);
      check($sformatf("transp%0d", d), ot[d], mt[d]);
    end
    rst_n = 1'b1; valid = 1'b0; wr_en = 1'b0; flash = 1'b0;
  endtask
  task automatic rnd_in();
    valid = 1'($urandom); pal = 2'($urandom); idx = 4'($urandom);
    wr_en = 1'($urandom); wr_pal = $urandom_range(1) ? pal : 2'($urandom);
    wr_idx = $urandom_range(1) ? idx : 4'($urandom); wr_data = 24'($urandom);
    flash = ($urandom_range(3) == 0);
  endtask
  task automatic wait_init(string tag, int exp_len);
    int n = 0;
    while (ob[0] === 1'b1 && n < 200) begin
      rnd_in();
      tick();
      n++;
    end
    check(tag, n, exp_len);
  endtask
  task automatic rd(int p, int i, bit f);
    valid = 1'b1; pal = 2'(p); idx = 4'(i); flash = f;
    tick(); tick(); tick();
  endtask
  task automatic wr(int p, int i, logic [23:0] data);
    wr_en = 1'b1; wr_pal = 2'(p); wr_idx = 4'(i); wr_data = data;
    tick();
  endtask
  initial begin
    rst_n = 1'b0;
    tick();
    check("rst_busy", ob[0], 1);
    wait_init("init_len", 64);
    rd(2, 15, 0);
    check("b2i15", oc[0], 24'hF0F0F0);
    check("b2i15_t", ot[0], 0);
    rd(2, 0, 0);
    check("b2i0", oc[0], 24'h000000);
    check("b2i0_t", ot[0], 1);
    wr(1, 3, 24'hACF52A);
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin valid = 1'b1; pal = 2'd1; idx = 4'(i); end
      tick();
      if (i >= 2) begin
        check("strm_v", ov[0], 1);
        check("strm_c", oc[0], (i - 2) == 3 ? 24'hACF52A : ramp(i - 2));
      end
    end
    tick();
    check("strm_end", ov[0], 0);
    rd(0, 3, 0);
    check("b0i3", oc[0], 24'h303030);
    valid = 1'b1; pal = 2'd0; idx = 4'd5;
    tick();
    wr(0, 5, 24'hDF52FF);
    tick();
    check("late_wr", oc[0], 24'h505050);
    valid = 1'b1; pal = 2'd0; idx = 4'd9;
    wr_en = 1'b1; wr_pal = 2'd0; wr_idx = 4'd9; wr_data = 24'hDF52FF;
    tick(); tick(); tick();
    check("bypass", oc[0], 24'hDF52FF);
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < 30; i++) begin rnd_in(); tick(); end
    rst_n = 1'b0;
    tick();
    wait_init("resweep", 64);
    rd(1, 3, 0);
    check("revert_b1i3", oc[0], 24'h303030);
    wr(2, 4, 24'hABCDEF);
    rd(2, 4, 0);
    check("wr_b2i4", oc[0], 24'hABCDEF);
    rst_n = 1'b0;
    tick();
    wait_init("run_rst", 64);
    rd(2, 4, 0);
    check("revert_b2i4", oc[0], 24'h404040);
    rd(3, 2, 0);
    check("oor_rd", oc[1], 24'h0);
    wr(3, 2, 24'h777777);
    rd(0, 2, 0);
    check("no_alias", oc[1], 24'h202020);
    rd(3, 2, 0);
    check("b3_np4", oc[0], 24'h777777);
    check("b3_np3", oc[1], 24'h0);
`ifdef PALETTE_FLASH_EN
    rd(0, 7, 1);
    check("flash7", oc[0], 24'hFFFFFF);
    rd(0, 0, 1);
    check("flash0", oc[0], 24'h000000);
    check("flash0_t", ot[0], 1);
    rd(0, 7, 0);
    check("noflash7", oc[0], 24'h707070);
`endif
    for (int i = 0; i < 800; i++) begin
      rnd_in();
      rst_n = ($urandom_range(299) != 0);
      tick();
    end
    for (int i = 0; i < 4; i++) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
